// File: rtl/client_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : client_requester_pkg
// Desc     : Shared enums and constants for the arbitration client slice.
// Revision : 1.0 - initial release
// ============================================================================
package client_requester_pkg;

    localparam int c_default_depth = 4;
    localparam int c_job_len_w     = 4;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CLIENT0,
        SEL_CLIENT1,
        SEL_CLIENT2
    } selection;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_GRANT,
        CTRL_WAIT_RELEASE
    } controller_state;

    typedef enum logic [1:0] {
        CLIENT_IDLE,
        CLIENT_REQ,
        CLIENT_HOLD,
        CLIENT_RELEASE
    } client_state;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        RELEASE
    } requester_state;

    // Saturating decrement: the hold counter stops at zero instead of wrapping.
    function automatic logic [c_job_len_w-1:0] dec_sat(input logic [c_job_len_w-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/client_requester_job_fifo.sv
`default_nettype none
// ============================================================================
// Module   : job_fifo
// Desc     : DEPTH-entry FIFO of job lengths with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Pointers wrap explicitly so non-power-of-two depths stay in range.
    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (r_count == c_cnt_w'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/client_requester.sv
`default_nettype none
// ============================================================================
// Module   : client_requester
// Desc     : Queues local jobs and runs a four-phase req/ack handshake per job.
// Revision : 1.0 - initial release
// ============================================================================
module client_requester #(
    parameter int DEPTH = client_requester_pkg::c_default_depth
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     job_valid,
    input  logic [3:0]               job_len,
    output logic                     job_ready,
    output logic                     req,
    input  logic                     ack,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   pending
);

    import client_requester_pkg::*;

    requester_state          r_state;
    requester_state          w_state_nxt;
    logic [c_job_len_w-1:0]  r_cnt;
    logic [c_job_len_w-1:0]  w_cnt_nxt;
    logic                    r_req;
    logic                    w_req_nxt;
    logic                    r_busy;
    logic                    w_busy_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    r_ack_low;
    logic                    w_ack_ok;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [c_job_len_w-1:0]  w_head;

    job_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_job_len_w)
    ) u_job_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (job_valid),
        .push_data (job_len),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (pending)
    );

    assign job_ready = ~w_full;
    assign req       = r_req;
    assign busy      = r_busy;
    assign done      = r_done;

    // A fresh request needs ack seen low since reset; the current cycle counts.
    assign w_ack_ok = r_ack_low | ~ack;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && w_ack_ok) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = w_head;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_req_nxt = 1'b1;
                if (ack) begin
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = RELEASE;
                end else begin
                    w_cnt_nxt = dec_sat(r_cnt);
                end
            end
            RELEASE: begin
                w_req_nxt = 1'b0;
                if (!ack) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_low <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_req     <= w_req_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ack_low <= r_ack_low | ~ack;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_client_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_client_requester
// Desc     : Directed self-checking bench for client_requester.
// Revision : 1.0 - initial release
// ============================================================================
module tb_client_requester;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       job_valid;
    logic [3:0] job_len;
    logic       job_ready;
    logic       req;
    logic       ack;
    logic       busy;
    logic       done;
    logic [2:0] pending;

    int vectors = 0;
    int errors  = 0;

    client_requester #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .job_valid (job_valid),
        .job_len   (job_len),
        .job_ready (job_ready),
        .req       (req),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Acts as the controller for one job: grant, count busy, release, await done.
    task automatic serve_job(input int len, input string tag);
        int n;
        int bc;
        n = 0;
        while (req !== 1'b1 && n < 30) begin step; n++; end
        vectors++; if (req !== 1'b1) begin errors++; $display("FAIL %s_req: req=%b want 1 (timeout)", tag, req); end
        step;
        ack = 1'b1;
        bc = 0; n = 0;
        do begin step; n++; if (busy === 1'b1) bc++; end while (req === 1'b1 && n < 30);
        vectors++; if (bc !== len + 1) begin errors++; $display("FAIL %s_busy_len: got %0d cycles want %0d", tag, bc, len + 1); end
        step;
        ack = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 10) begin step; n++; end
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done: done=%b want 1 (timeout)", tag, done); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; job_valid = 1'b0; job_len = 4'd0; ack = 1'b0;
        step; step;
        vectors++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending); end
        vectors++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", job_ready); end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_single;
        int n;
        int bc;
        job_valid = 1'b1; job_len = 4'd2;
        step;
        job_valid = 1'b0;
        vectors++; if (pending !== 3'd1) begin errors++; $display("FAIL single_pending1: got %0d want 1", pending); end
        vectors++; if (req !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b want 0", req); end
        step;
        vectors++; if (req !== 1'b1) begin errors++; $display("FAIL single_req_rise: got %b want 1", req); end
        vectors++; if (pending !== 3'd0) begin errors++; $display("FAIL single_pending0: got %0d want 0", pending); end
        step;
        step;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_early: got %b want 0", busy); end
        ack = 1'b1;
        bc = 0; n = 0;
        do begin step; n++; if (busy === 1'b1) bc++; end while (req === 1'b1 && n < 20);
        vectors++; if (bc !== 3) begin errors++; $display("FAIL single_busy_cycles: got %0d want 3", bc); end
        vectors++; if (n !== 4) begin errors++; $display("FAIL single_req_fall: got %0d cycles want 4", n); end
        step;
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b want 0", done); end
        ack = 1'b0;
        step;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done); end
        step;
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", done); end
        vectors++; if (pending !== 3'd0) begin errors++; $display("FAIL single_pending_end: got %0d want 0", pending); end
    endtask

    task automatic test_len0;
        job_valid = 1'b1; job_len = 4'd0;
        step;
        job_valid = 1'b0;
        step;
        vectors++; if (req !== 1'b1) begin errors++; $display("FAIL len0_req: got %b want 1", req); end
        ack = 1'b1;
        step;
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL len0_busy: got %b want 1", busy); end
        step;
        vectors++; if (req !== 1'b0) begin errors++; $display("FAIL len0_req_fall: got %b want 0", req); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy_fall: got %b want 0", busy); end
        step;
        ack = 1'b0;
        step;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b want 1", done); end
        step;
    endtask

    task automatic test_full;
        int lens [5] = '{3, 1, 4, 2, 5};
        int idx;
        logic acc;
        job_valid = 1'b1; job_len = 4'd0;
        step;
        job_valid = 1'b0;
        step;
        vectors++; if (req !== 1'b1) begin errors++; $display("FAIL full_first_req: got %b want 1", req); end
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            job_valid = 1'b1;
            job_len   = 4'(lens[idx]);
            acc       = job_ready;
            step;
            if (acc) idx++;
        end
        vectors++; if (idx !== 4) begin errors++; $display("FAIL full_accepted: got %0d want 4", idx); end
        vectors++; if (pending !== 3'd4) begin errors++; $display("FAIL full_pending: got %0d want 4", pending); end
        vectors++; if (job_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", job_ready); end
        serve_job(0, "full_a");
        vectors++; if (pending !== 3'd4) begin errors++; $display("FAIL full_pending_hold: got %0d want 4", pending); end
        step;
        vectors++; if (pending !== 3'd3) begin errors++; $display("FAIL full_pending_pop: got %0d want 3", pending); end
        vectors++; if (job_ready !== 1'b1) begin errors++; $display("FAIL full_ready_again: got %b want 1", job_ready); end
        step;
        job_valid = 1'b0;
        vectors++; if (pending !== 3'd4) begin errors++; $display("FAIL full_fifth_in: got %0d want 4", pending); end
        serve_job(3, "full_j1");
        serve_job(1, "full_j2");
        serve_job(4, "full_j3");
        serve_job(2, "full_j4");
        serve_job(5, "full_j5");
        vectors++; if (pending !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", pending); end
        step;
    endtask

    task automatic test_push_pop;
        job_valid = 1'b1; job_len = 4'd1;
        step;
        job_len = 4'd2;
        step;
        job_len = 4'd3;
        step;
        job_valid = 1'b0;
        vectors++; if (pending !== 3'd2) begin errors++; $display("FAIL pp_pending_pre: got %0d want 2", pending); end
        serve_job(1, "pp_x");
        job_valid = 1'b1; job_len = 4'd4;
        step;
        job_valid = 1'b0;
        vectors++; if (pending !== 3'd2) begin errors++; $display("FAIL pp_pending_same: got %0d want 2", pending); end
        vectors++; if (req !== 1'b1) begin errors++; $display("FAIL pp_req: got %b want 1", req); end
        serve_job(2, "pp_y");
        serve_job(3, "pp_z");
        serve_job(4, "pp_w");
        vectors++; if (pending !== 3'd0) begin errors++; $display("FAIL pp_drained: got %0d want 0", pending); end
        step;
    endtask

    task automatic test_reset_mid_hold;
        int n;
        job_valid = 1'b1; job_len = 4'd10;
        step;
        job_len = 4'd1;
        step; step; step;
        job_valid = 1'b0;
        vectors++; if (pending !== 3'd3) begin errors++; $display("FAIL rst_pending_pre: got %0d want 3", pending); end
        ack = 1'b1;
        step; step;
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_pre: got %b want 1", busy); end
        rst_n = 1'b0;
        step;
        vectors++; if (req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b want 0", req); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        vectors++; if (pending !== 3'd0) begin errors++; $display("FAIL rst_mid_pending: got %0d want 0", pending); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", done); end
        rst_n = 1'b1; job_valid = 1'b1; job_len = 4'd1;
        step;
        job_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step;
            vectors++; if (req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_ack_high_req: req=%b done=%b want 0 0", req, done); end
        end
        vectors++; if (pending !== 3'd1) begin errors++; $display("FAIL rst_queued: got %0d want 1", pending); end
        ack = 1'b0;
        n = 0;
        while (req !== 1'b1 && n < 5) begin step; n++; end
        vectors++; if (n !== 1) begin errors++; $display("FAIL rst_req_after_ack_low: got %0d cycles want 1", n); end
        serve_job(1, "rst_after");
        step;
    endtask

    task automatic test_ack_held;
        job_valid = 1'b1; job_len = 4'd0;
        step;
        job_len = 4'd1;
        step;
        job_valid = 1'b0;
        vectors++; if (req !== 1'b1) begin errors++; $display("FAIL held_req: got %b want 1", req); end
        ack = 1'b1;
        step; step;
        vectors++; if (req !== 1'b0) begin errors++; $display("FAIL held_release: got %b want 0", req); end
        for (int c = 0; c < 5; c++) begin
            step;
            vectors++; if (req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL held_stay: req=%b done=%b want 0 0", req, done); end
        end
        ack = 1'b0;
        step;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL held_done: got %b want 1", done); end
        step;
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL held_done_width: got %b want 0", done); end
        vectors++; if (req !== 1'b1) begin errors++; $display("FAIL held_next_req: got %b want 1", req); end
        serve_job(1, "held_next");
        vectors++; if (pending !== 3'd0) begin errors++; $display("FAIL held_drained: got %0d want 0", pending); end
        step;
    endtask

    initial begin
        test_reset();
        test_single();
        test_len0();
        test_full();
        test_push_pop();
        test_reset_mid_hold();
        test_ack_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
